// File: rtl/psum_drain_pkg.sv
// Shared types, constants and saturating-add helper for the psum drain collector.
package psum_drain_pkg;

  localparam int unsigned DATA_WIDTH       = 16;
  localparam int unsigned ARRAY_LENGTH     = 3;
  localparam int unsigned OUT_DEPTH        = 16;
  localparam int unsigned MAX_CONFIG_WIDTH = 8;

  localparam int unsigned IDX_W  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int unsigned LANE_W = (ARRAY_LENGTH > 1) ? $clog2(ARRAY_LENGTH) : 1;
  localparam int unsigned BUS_W  = DATA_WIDTH * ARRAY_LENGTH;

  typedef logic signed [DATA_WIDTH-1:0] psum_t;

  localparam psum_t SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam psum_t SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    FINISH  = 2'd3
  } state_t;

  typedef struct packed {
    logic  ovf;
    psum_t sum;
  } sat_sum_t;

  // Signed add clamped to the psum range; ovf flags that a clamp happened.
  function automatic sat_sum_t sat_add(input psum_t a, input psum_t b);
    logic [DATA_WIDTH:0] wide;
    sat_sum_t            res;
    wide    = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
    res.ovf = wide[DATA_WIDTH] ^ wide[DATA_WIDTH-1];
    if (!res.ovf)            res.sum = psum_t'(wide[DATA_WIDTH-1:0]);
    else if (wide[DATA_WIDTH]) res.sum = SAT_MIN;
    else                     res.sum = SAT_MAX;
    return res;
  endfunction

endpackage

// File: rtl/psum_drain_collector_if.sv
// Array-side psum pop handshake and global-buffer valid/ready link.
interface psum_drain_collector_if;
  import psum_drain_pkg::*;

  logic [BUS_W-1:0]      data_psum_in;
  logic                  psum_out_valid;
  logic                  psum_read_en;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  // Environment side: PE array plus global buffer.
  modport master (
    output data_psum_in, psum_out_valid, out_ready,
    input  psum_read_en, out_data, out_valid, out_last
  );

  // Collector side.
  modport slave (
    input  data_psum_in, psum_out_valid, out_ready,
    output psum_read_en, out_data, out_valid, out_last
  );
endinterface

// File: rtl/psum_acc_bank.sv
// ARRAY_LENGTH x OUT_DEPTH accumulator bank: parallel lane write/accumulate,
// one registered read port. Optional ReLU on read (macro PSUM_DRAIN_RELU_EN).
module psum_acc_bank
  import psum_drain_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  wr_first,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [BUS_W-1:0]      wr_data,
  output logic                  sat_c,
  input  logic                  rd_en,
  input  logic [LANE_W-1:0]     rd_lane,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data
);

  psum_t                   acc      [ARRAY_LENGTH][OUT_DEPTH];
  sat_sum_t                lane_sum [ARRAY_LENGTH];
  psum_t                   wr_val   [ARRAY_LENGTH];
  logic [ARRAY_LENGTH-1:0] lane_ovf;
  psum_t                   rd_word;

  // Per-lane overwrite on the first pass, saturating accumulate afterwards
  always_comb begin
    for (int r = 0; r < ARRAY_LENGTH; r++) begin
      lane_sum[r] = sat_add(acc[r][wr_idx], psum_t'(wr_data[r*DATA_WIDTH +: DATA_WIDTH]));
      wr_val[r]   = wr_first ? psum_t'(wr_data[r*DATA_WIDTH +: DATA_WIDTH]) : lane_sum[r].sum;
      lane_ovf[r] = lane_sum[r].ovf & ~wr_first;
    end
    sat_c = wr_en & (|lane_ovf);
  end

  // Accumulator storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int r = 0; r < ARRAY_LENGTH; r++) acc[r][wr_idx] <= wr_val[r];
    end
  end

  // Read mux with write-through so the first drain word can follow the final write
  always_comb begin
    rd_word = (wr_en && (wr_idx == rd_idx)) ? wr_val[rd_lane] : acc[rd_lane][rd_idx];
`ifdef PSUM_DRAIN_RELU_EN
    if (rd_word[DATA_WIDTH-1]) rd_word = '0;
`endif
  end

  // Registered read port feeding the output word
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= rd_word;
  end

endmodule

// File: rtl/psum_drain_collector.sv
// Pops lane psums from the PE array, accumulates across passes, then drains
// the ofmap row-major to the global buffer. Optional macro: PSUM_DRAIN_RELU_EN.
module psum_drain_collector
  import psum_drain_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [MAX_CONFIG_WIDTH-1:0] num_passes,
  input  logic [MAX_CONFIG_WIDTH-1:0] out_len,
  psum_drain_collector_if.slave       bus,
  output logic                        busy,
  output logic                        done,
  output logic                        sat_flag
);

  state_t                      state, state_n;
  logic [IDX_W-1:0]            idx, idx_n, len_m1, len_m1_n, d_idx, d_idx_n;
  logic [LANE_W-1:0]           d_lane, d_lane_n;
  logic [MAX_CONFIG_WIDTH-1:0] pass, pass_n, passes_m1, passes_m1_n;
  logic [MAX_CONFIG_WIDTH-1:0] len_eff, passes_eff;
  logic                        out_valid, out_valid_n, out_last, out_last_n, sat_flag_n;
  logic                        read_en_c, load_c, sat_c;
  logic [DATA_WIDTH-1:0]       rd_data;

  // Zero and clamp rules for the job configuration
  always_comb begin
    len_eff = out_len;
    if (out_len == '0)                               len_eff = MAX_CONFIG_WIDTH'(1);
    else if (out_len > MAX_CONFIG_WIDTH'(OUT_DEPTH)) len_eff = MAX_CONFIG_WIDTH'(OUT_DEPTH);
    passes_eff = (num_passes == '0) ? MAX_CONFIG_WIDTH'(1) : num_passes;
  end

  // Next-state, counters and handshake decode
  always_comb begin
    state_n     = state;
    idx_n       = idx;
    pass_n      = pass;
    len_m1_n    = len_m1;
    passes_m1_n = passes_m1;
    d_idx_n     = d_idx;
    d_lane_n    = d_lane;
    out_valid_n = out_valid;
    out_last_n  = out_last;
    sat_flag_n  = sat_flag;
    read_en_c   = 1'b0;
    load_c      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n     = COLLECT;
          idx_n       = '0;
          pass_n      = '0;
          d_idx_n     = '0;
          d_lane_n    = '0;
          sat_flag_n  = 1'b0;
          len_m1_n    = IDX_W'(len_eff - MAX_CONFIG_WIDTH'(1));
          passes_m1_n = passes_eff - MAX_CONFIG_WIDTH'(1);
        end
      end
      COLLECT: begin
        read_en_c = bus.psum_out_valid;
        if (read_en_c) begin
          sat_flag_n = sat_flag | sat_c;
          if (idx == len_m1) begin
            idx_n = '0;
            if (pass == passes_m1) begin
              state_n = DRAIN;
              load_c  = 1'b1;
            end else begin
              pass_n = pass + MAX_CONFIG_WIDTH'(1);
            end
          end else begin
            idx_n = idx + IDX_W'(1);
          end
        end
      end
      DRAIN: begin
        if (out_valid && bus.out_ready) begin
          if (out_last) begin
            out_valid_n = 1'b0;
            out_last_n  = 1'b0;
            state_n     = FINISH;
          end else begin
            load_c = 1'b1;
          end
        end
      end
      FINISH: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (load_c) begin
      out_valid_n = 1'b1;
      out_last_n  = (d_lane == LANE_W'(ARRAY_LENGTH - 1)) && (d_idx == len_m1);
      if (d_idx == len_m1) begin
        d_idx_n  = '0;
        d_lane_n = d_lane + LANE_W'(1);
      end else begin
        d_idx_n = d_idx + IDX_W'(1);
      end
    end
  end

  // State and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      pass      <= '0;
      len_m1    <= '0;
      passes_m1 <= '0;
      d_idx     <= '0;
      d_lane    <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      sat_flag  <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      pass      <= pass_n;
      len_m1    <= len_m1_n;
      passes_m1 <= passes_m1_n;
      d_idx     <= d_idx_n;
      d_lane    <= d_lane_n;
      out_valid <= out_valid_n;
      out_last  <= out_last_n;
      sat_flag  <= sat_flag_n;
    end
  end

  psum_acc_bank u_bank (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (read_en_c),
    .wr_first (pass == '0),
    .wr_idx   (idx),
    .wr_data  (bus.data_psum_in),
    .sat_c    (sat_c),
    .rd_en    (load_c),
    .rd_lane  (d_lane),
    .rd_idx   (d_idx),
    .rd_data  (rd_data)
  );

  assign bus.psum_read_en = read_en_c;
  assign bus.out_data     = rd_data;
  assign bus.out_valid    = out_valid;
  assign bus.out_last     = out_last;
  assign busy             = (state != IDLE);
  assign done             = (state == FINISH);

endmodule

// File: tb/tb_psum_drain_collector.sv
// Directed self-checking bench for psum_drain_collector.
module tb_psum_drain_collector;
  import psum_drain_pkg::*;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] num_passes;
  logic [7:0] out_len;
  logic       busy, done, sat_flag;

  psum_drain_collector_if bus ();

  psum_drain_collector dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_passes (num_passes),
    .out_len    (out_len),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .sat_flag   (sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [BUS_W-1:0]      beat_q [$];
  logic [DATA_WIDTH-1:0] got_q  [$];
  bit                    last_q [$];
  bit                    ready_pat [$];
  bit  hold_valid;
  int  restart_at;
  int  pops, stall_err, bubble_err, done_cnt;
  int  last_pop_cyc, first_valid_cyc, last_word_cyc, done_cyc;
  bit  timeout;

  function automatic logic [BUS_W-1:0] lanes(input int a, input int b, input int c);
    return {16'(c), 16'(b), 16'(a)};
  endfunction

  // Runs one job cycle by cycle: feeds beat_q, drives out_ready from ready_pat, records words.
  task automatic run_job(input logic [7:0] np, input logic [7:0] ol, input int max_cyc);
    int cyc, k, done_at;
    bit prev_stall, prev_hs;
    logic [DATA_WIDTH-1:0] prev_data;
    got_q.delete(); last_q.delete();
    pops = 0; stall_err = 0; bubble_err = 0; done_cnt = 0; timeout = 0;
    last_pop_cyc = -1; first_valid_cyc = -1; last_word_cyc = -1; done_cyc = -1;
    cyc = 0; k = 0; done_at = -1; prev_stall = 0; prev_hs = 0; prev_data = '0;
    while (1) begin
      @(negedge clk);
      if (prev_stall && (!bus.out_valid || bus.out_data !== prev_data)) stall_err++;
      if (prev_hs && !bus.out_valid) bubble_err++;
      if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (done) begin
        done_cnt++;
        if (done_at < 0) begin done_at = cyc; done_cyc = cyc; end
      end
      if (done_at >= 0 && cyc >= done_at + 2) break;
      if (cyc >= max_cyc) begin timeout = 1; break; end
      start      = (cyc == 0) || (cyc == restart_at);
      num_passes = (cyc == 0) ? np : 8'd5;
      out_len    = (cyc == 0) ? ol : 8'd9;
      if (bus.out_valid) begin
        bus.out_ready = ready_pat[k % ready_pat.size()];
        k++;
      end else begin
        bus.out_ready = 1'b1;
      end
      bus.psum_out_valid = (beat_q.size() > 0) || hold_valid;
      bus.data_psum_in   = (beat_q.size() > 0) ? beat_q[0] : 48'hDEAD_BEEF_CAFE;
      #1;
      if (bus.psum_read_en && bus.psum_out_valid) begin
        pops++;
        last_pop_cyc = cyc;
        if (beat_q.size() > 0) void'(beat_q.pop_front());
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_hs    = bus.out_valid && bus.out_ready && !bus.out_last;
      if (bus.out_valid && bus.out_ready) begin
        got_q.push_back(bus.out_data);
        last_q.push_back(bus.out_last);
        last_word_cyc = cyc;
      end
      cyc++;
    end
    start = 1'b0;
    bus.psum_out_valid = 1'b0;
    beat_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.psum_out_valid = 1'b1;
    @(negedge clk); #1;
    checks++; if (bus.psum_read_en !== 1'b0) begin failures++; $display("FAIL reset_read_en got=%b want=0", bus.psum_read_en); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    checks++; if (bus.out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b want=0", bus.out_last); end
    checks++; if (bus.out_data !== 16'h0) begin failures++; $display("FAIL reset_out_data got=%h want=0000", bus.out_data); end
    checks++; if ({busy, done, sat_flag} !== 3'b000) begin failures++; $display("FAIL reset_status got=%b want=000", {busy, done, sat_flag}); end
    bus.psum_out_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_pass();
    logic [15:0] exp_w [6] = '{16'd1, 16'd4, 16'd2, 16'd5, 16'd3, 16'd6};
    hold_valid = 1'b1;
    beat_q.push_back(lanes(1, 2, 3));
    beat_q.push_back(lanes(4, 5, 6));
    run_job(8'd1, 8'd2, 200);
    hold_valid = 1'b0;
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL single_timeout got=1 want=0"); end
    checks++; if (pops !== 2) begin failures++; $display("FAIL single_pops got=%0d want=2", pops); end
    checks++; if (got_q.size() !== 6) begin failures++; $display("FAIL single_count got=%0d want=6", got_q.size()); end
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_w[i]) begin failures++; $display("FAIL single_word%0d got=%h want=%h", i, got_q[i], exp_w[i]); end
      checks++; if (last_q[i] !== (i == 5)) begin failures++; $display("FAIL single_last%0d got=%b want=%b", i, last_q[i], (i == 5)); end
    end
    checks++; if (first_valid_cyc - last_pop_cyc !== 1) begin failures++; $display("FAIL single_latency got=%0d want=1", first_valid_cyc - last_pop_cyc); end
    checks++; if (done_cyc - last_word_cyc !== 1) begin failures++; $display("FAIL single_done_timing got=%0d want=1", done_cyc - last_word_cyc); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL single_done_count got=%0d want=1", done_cnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_after got=%b want=0", busy); end
  endtask

  task automatic test_saturation();
    logic [15:0] exp_hi, exp_lo;
    exp_hi = 16'h7FFF;
`ifdef PSUM_DRAIN_RELU_EN
    exp_lo = 16'h0000;
`else
    exp_lo = 16'h8000;
`endif
    beat_q.push_back(lanes(16'h7000, 0, 0));
    beat_q.push_back(lanes(16'h7000, 0, 0));
    run_job(8'd2, 8'd1, 200);
    checks++; if (got_q.size() !== 3) begin failures++; $display("FAIL sat_pos_count got=%0d want=3", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== exp_hi) begin failures++; $display("FAIL sat_pos_word got=%h want=%h", got_q[0], exp_hi); end
    end
    checks++; if (sat_flag !== 1'b1) begin failures++; $display("FAIL sat_pos_flag got=%b want=1", sat_flag); end
    beat_q.push_back(lanes(16'h9000, 0, 0));
    beat_q.push_back(lanes(16'h9000, 0, 0));
    run_job(8'd2, 8'd1, 200);
    checks++; if (got_q.size() !== 3) begin failures++; $display("FAIL sat_neg_count got=%0d want=3", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== exp_lo) begin failures++; $display("FAIL sat_neg_word got=%h want=%h", got_q[0], exp_lo); end
    end
    checks++; if (sat_flag !== 1'b1) begin failures++; $display("FAIL sat_neg_flag got=%b want=1", sat_flag); end
  endtask

  task automatic test_multi_pass();
`ifdef PSUM_DRAIN_RELU_EN
    logic [15:0] exp_w [3] = '{16'd30, 16'd0, 16'd0};
`else
    logic [15:0] exp_w [3] = '{16'd30, 16'hFFF1, 16'd0};
`endif
    repeat (3) beat_q.push_back(lanes(10, -5, 0));
    run_job(8'd3, 8'd1, 200);
    checks++; if (pops !== 3) begin failures++; $display("FAIL multi_pops got=%0d want=3", pops); end
    checks++; if (got_q.size() !== 3) begin failures++; $display("FAIL multi_count got=%0d want=3", got_q.size()); end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_w[i]) begin failures++; $display("FAIL multi_word%0d got=%h want=%h", i, got_q[i], exp_w[i]); end
    end
    checks++; if (sat_flag !== 1'b0) begin failures++; $display("FAIL multi_sat_cleared got=%b want=0", sat_flag); end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_w [6] = '{16'h11, 16'h44, 16'h22, 16'h55, 16'h33, 16'h66};
    ready_pat.delete();
    ready_pat.push_back(1'b1); ready_pat.push_back(1'b0);
    ready_pat.push_back(1'b0); ready_pat.push_back(1'b1);
    beat_q.push_back(lanes(16'h11, 16'h22, 16'h33));
    beat_q.push_back(lanes(16'h44, 16'h55, 16'h66));
    run_job(8'd1, 8'd2, 200);
    ready_pat.delete(); ready_pat.push_back(1'b1);
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL bp_timeout got=1 want=0"); end
    checks++; if (stall_err !== 0) begin failures++; $display("FAIL bp_stall_stable got=%0d want=0", stall_err); end
    checks++; if (bubble_err !== 0) begin failures++; $display("FAIL bp_bubble got=%0d want=0", bubble_err); end
    checks++; if (got_q.size() !== 6) begin failures++; $display("FAIL bp_count got=%0d want=6", got_q.size()); end
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_w[i]) begin failures++; $display("FAIL bp_word%0d got=%h want=%h", i, got_q[i], exp_w[i]); end
    end
  endtask

  task automatic test_boundaries();
    logic [15:0] exp_z [3] = '{16'd7, 16'd8, 16'd9};
    logic [15:0] exp_r [6] = '{16'd11, 16'd44, 16'd22, 16'd55, 16'd33, 16'd66};
    // zero config behaves as 1/1
    beat_q.push_back(lanes(7, 8, 9));
    run_job(8'd0, 8'd0, 200);
    checks++; if (pops !== 1) begin failures++; $display("FAIL zero_pops got=%0d want=1", pops); end
    checks++; if (got_q.size() !== 3) begin failures++; $display("FAIL zero_count got=%0d want=3", got_q.size()); end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_z[i]) begin failures++; $display("FAIL zero_word%0d got=%h want=%h", i, got_q[i], exp_z[i]); end
    end
    // out_len=40 clamps to 16
    hold_valid = 1'b1;
    for (int i = 0; i < 16; i++) beat_q.push_back(lanes(i, 100 + i, 200 + i));
    run_job(8'd1, 8'd40, 400);
    hold_valid = 1'b0;
    checks++; if (pops !== 16) begin failures++; $display("FAIL clamp_pops got=%0d want=16", pops); end
    checks++; if (got_q.size() !== 48) begin failures++; $display("FAIL clamp_count got=%0d want=48", got_q.size()); end
    for (int i = 0; i < 48 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== 16'((i / 16) * 100 + (i % 16))) begin
        failures++; $display("FAIL clamp_word%0d got=%0d want=%0d", i, got_q[i], (i / 16) * 100 + (i % 16));
      end
    end
    checks++; if (last_q.size() == 48 && last_q[47] !== 1'b1) begin failures++; $display("FAIL clamp_last got=0 want=1"); end
    // start during COLLECT is ignored
    restart_at = 2;
    beat_q.push_back(lanes(1, 2, 3));
    beat_q.push_back(lanes(4, 5, 6));
    beat_q.push_back(lanes(10, 20, 30));
    beat_q.push_back(lanes(40, 50, 60));
    run_job(8'd2, 8'd2, 200);
    restart_at = -1;
    checks++; if (pops !== 4) begin failures++; $display("FAIL restart_pops got=%0d want=4", pops); end
    checks++; if (got_q.size() !== 6) begin failures++; $display("FAIL restart_count got=%0d want=6", got_q.size()); end
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_r[i]) begin failures++; $display("FAIL restart_word%0d got=%h want=%h", i, got_q[i], exp_r[i]); end
    end
  endtask

  task automatic test_reset_mid_drain();
    logic [15:0] exp_w [3] = '{16'd100, 16'd200, 16'd300};
    @(negedge clk);
    start = 1'b1; num_passes = 8'd1; out_len = 8'd1;
    bus.psum_out_valid = 1'b1; bus.data_psum_in = lanes(3, 2, 1); bus.out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++; if ({bus.out_valid, busy} !== 2'b11) begin failures++; $display("FAIL rstmid_pre got=%b want=11", {bus.out_valid, busy}); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid got=%b want=0", bus.out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    checks++; if (bus.psum_read_en !== 1'b0) begin failures++; $display("FAIL rstmid_read_en got=%b want=0", bus.psum_read_en); end
    bus.psum_out_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    beat_q.push_back(lanes(100, 200, 300));
    run_job(8'd1, 8'd1, 200);
    checks++; if (got_q.size() !== 3) begin failures++; $display("FAIL rstmid_count got=%0d want=3", got_q.size()); end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_w[i]) begin failures++; $display("FAIL rstmid_word%0d got=%h want=%h", i, got_q[i], exp_w[i]); end
    end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL rstmid_done got=%0d want=1", done_cnt); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_passes = '0; out_len = '0;
    bus.psum_out_valid = 1'b0; bus.data_psum_in = '0; bus.out_ready = 1'b1;
    hold_valid = 1'b0; restart_at = -1;
    ready_pat.push_back(1'b1);
    test_reset();
    test_single_pass();
    test_saturation();
    test_multi_pass();
    test_backpressure();
    test_boundaries();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
